// File: rtl/riscv_core_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | riscv_core_pkg : FSM state types and AXI encodings for the bus arbiter   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package riscv_core_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_fsm_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_RESP = 2'd2
  } wr_fsm_e;

  localparam logic [2:0] AXI_SIZE_WORD = 3'b010;
  localparam logic [3:0] AXI_CACHE_DEV = 4'b0000;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arbiter2 : two-requester round-robin arbiter with priority override   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       prio1_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  // ptr_q = 1 means requester 1 has priority on the next contended cycle
  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = (prio1_i || ptr_q) ? 2'b10 : 2'b01;
    end
    ptr_d = ptr_q;
    if (accept_i && (gnt_o != 2'b00)) begin
      ptr_d = gnt_o[0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_core_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_core_bus_arbiter : merges core I-read, D-read and D-write ports onto |
// | one AXI4-lite master, one read and one write outstanding. Revision 1.0   |
// +--------------------------------------------------------------------------+
module axi_core_bus_arbiter
  import riscv_core_pkg::*;
#(
  parameter string ARB_MODE   = "RR",
  parameter int    ADDR_WIDTH = 32,
  parameter int    DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  i_arvalid_i,
  output logic                  i_arready_o,
  input  logic [ADDR_WIDTH-1:0] i_araddr_i,
  input  logic [2:0]            i_arprot_i,
  input  logic [3:0]            i_arcache_i,
  input  logic [1:0]            i_arsize_i,
  output logic                  i_rvalid_o,
  input  logic                  i_rready_i,
  output logic [DATA_WIDTH-1:0] i_rdata_o,
  input  logic                  d_arvalid_i,
  output logic                  d_arready_o,
  input  logic [ADDR_WIDTH-1:0] d_araddr_i,
  input  logic [2:0]            d_arprot_i,
  output logic                  d_rvalid_o,
  input  logic                  d_rready_i,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  input  logic                  d_awvalid_i,
  output logic                  d_awready_o,
  input  logic [ADDR_WIDTH-1:0] d_awaddr_i,
  input  logic [2:0]            d_awprot_i,
  input  logic                  d_wvalid_i,
  output logic                  d_wready_o,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  input  logic [3:0]            d_wstrb_i,
  output logic                  d_bvalid_o,
  input  logic                  d_bready_i,
  output logic                  m_arvalid_o,
  input  logic                  m_arready_i,
  output logic [ADDR_WIDTH-1:0] m_araddr_o,
  output logic [2:0]            m_arprot_o,
  output logic [3:0]            m_arcache_o,
  output logic [2:0]            m_arsize_o,
  input  logic                  m_rvalid_i,
  output logic                  m_rready_o,
  input  logic [DATA_WIDTH-1:0] m_rdata_i,
  output logic                  m_awvalid_o,
  input  logic                  m_awready_i,
  output logic [ADDR_WIDTH-1:0] m_awaddr_o,
  output logic [2:0]            m_awprot_o,
  output logic                  m_wvalid_o,
  input  logic                  m_wready_i,
  output logic [DATA_WIDTH-1:0] m_wdata_o,
  output logic [3:0]            m_wstrb_o,
  input  logic                  m_bvalid_i,
  output logic                  m_bready_o,
  output logic                  rd_grant_o
);

  localparam bit DATA_FIRST = (ARB_MODE == "DATA_FIRST");

  rd_fsm_e               rd_state_q, rd_state_d;
  logic                  rd_grant_q, rd_grant_d;
  logic [ADDR_WIDTH-1:0] m_araddr_q, m_araddr_d;
  logic [2:0]            m_arprot_q, m_arprot_d;
  logic [3:0]            m_arcache_q, m_arcache_d;
  logic [2:0]            m_arsize_q, m_arsize_d;

  wr_fsm_e               wr_state_q, wr_state_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  w_cap_q, w_cap_d;
  logic [ADDR_WIDTH-1:0] m_awaddr_q, m_awaddr_d;
  logic [2:0]            m_awprot_q, m_awprot_d;
  logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
  logic [3:0]            m_wstrb_q, m_wstrb_d;

  logic [1:0] rd_req;
  logic [1:0] rd_gnt;
  logic       rd_owns_data;
  logic       wr_start;
  logic       aw_fire;
  logic       w_fire;

  // A data read may only be considered once no write is in flight
  assign rd_req       = {d_arvalid_i && (wr_state_q == W_IDLE), i_arvalid_i};
  assign rd_owns_data = rd_grant_q && (rd_state_q != R_IDLE);
  // A pending data read beats a write that arrives in the same cycle
  assign wr_start     = d_awvalid_i && !d_arvalid_i && !rd_owns_data;

  rr_arbiter2 u_rr_arbiter2 (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (rd_req),
    .prio1_i  (DATA_FIRST),
    .accept_i (rd_state_q == R_IDLE),
    .gnt_o    (rd_gnt)
  );

  always_comb begin
    rd_state_d  = rd_state_q;
    rd_grant_d  = rd_grant_q;
    m_araddr_d  = m_araddr_q;
    m_arprot_d  = m_arprot_q;
    m_arcache_d = m_arcache_q;
    m_arsize_d  = m_arsize_q;
    i_arready_o = 1'b0;
    d_arready_o = 1'b0;
    m_arvalid_o = 1'b0;
    m_rready_o  = 1'b0;
    i_rvalid_o  = 1'b0;
    d_rvalid_o  = 1'b0;
    i_rdata_o   = '0;
    d_rdata_o   = '0;
    case (rd_state_q)
      R_IDLE: begin
        if (rd_gnt[0]) begin
          i_arready_o = 1'b1;
          rd_grant_d  = 1'b0;
          m_araddr_d  = i_araddr_i;
          m_arprot_d  = i_arprot_i;
          m_arcache_d = i_arcache_i;
          m_arsize_d  = {1'b0, i_arsize_i};
          rd_state_d  = R_ADDR;
        end else if (rd_gnt[1]) begin
          d_arready_o = 1'b1;
          rd_grant_d  = 1'b1;
          m_araddr_d  = d_araddr_i;
          m_arprot_d  = d_arprot_i;
          m_arcache_d = AXI_CACHE_DEV;
          m_arsize_d  = AXI_SIZE_WORD;
          rd_state_d  = R_ADDR;
        end
      end
      R_ADDR: begin
        m_arvalid_o = 1'b1;
        if (m_arready_i) begin
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rd_grant_q) begin
          d_rvalid_o = m_rvalid_i;
          d_rdata_o  = m_rdata_i;
          m_rready_o = d_rready_i;
        end else begin
          i_rvalid_o = m_rvalid_i;
          i_rdata_o  = m_rdata_i;
          m_rready_o = i_rready_i;
        end
        if (m_rvalid_i && m_rready_o) begin
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d  = wr_state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    w_cap_d     = w_cap_q;
    m_awaddr_d  = m_awaddr_q;
    m_awprot_d  = m_awprot_q;
    m_wdata_d   = m_wdata_q;
    m_wstrb_d   = m_wstrb_q;
    d_awready_o = 1'b0;
    d_wready_o  = 1'b0;
    d_bvalid_o  = 1'b0;
    m_awvalid_o = 1'b0;
    m_wvalid_o  = 1'b0;
    m_bready_o  = 1'b0;
    aw_fire     = 1'b0;
    w_fire      = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (wr_start) begin
          d_awready_o = 1'b1;
          m_awaddr_d  = d_awaddr_i;
          m_awprot_d  = d_awprot_i;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          w_cap_d     = 1'b0;
          if (d_wvalid_i) begin
            d_wready_o = 1'b1;
            m_wdata_d  = d_wdata_i;
            m_wstrb_d  = d_wstrb_i;
            w_cap_d    = 1'b1;
          end
          wr_state_d = W_ADDR;
        end
      end
      W_ADDR: begin
        m_awvalid_o = !aw_done_q;
        m_wvalid_o  = w_cap_q && !w_done_q;
        d_wready_o  = !w_cap_q;
        if (!w_cap_q && d_wvalid_i) begin
          m_wdata_d = d_wdata_i;
          m_wstrb_d = d_wstrb_i;
          w_cap_d   = 1'b1;
        end
        aw_fire   = !aw_done_q && m_awready_i;
        w_fire    = w_cap_q && !w_done_q && m_wready_i;
        aw_done_d = aw_done_q || aw_fire;
        w_done_d  = w_done_q || w_fire;
        if (aw_done_d && w_done_d) begin
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        d_bvalid_o = m_bvalid_i;
        m_bready_o = d_bready_i;
        if (m_bvalid_i && d_bready_i) begin
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_state_q  <= R_IDLE;
      rd_grant_q  <= 1'b0;
      m_araddr_q  <= '0;
      m_arprot_q  <= '0;
      m_arcache_q <= '0;
      m_arsize_q  <= '0;
      wr_state_q  <= W_IDLE;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      w_cap_q     <= 1'b0;
      m_awaddr_q  <= '0;
      m_awprot_q  <= '0;
      m_wdata_q   <= '0;
      m_wstrb_q   <= '0;
    end else begin
      rd_state_q  <= rd_state_d;
      rd_grant_q  <= rd_grant_d;
      m_araddr_q  <= m_araddr_d;
      m_arprot_q  <= m_arprot_d;
      m_arcache_q <= m_arcache_d;
      m_arsize_q  <= m_arsize_d;
      wr_state_q  <= wr_state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      w_cap_q     <= w_cap_d;
      m_awaddr_q  <= m_awaddr_d;
      m_awprot_q  <= m_awprot_d;
      m_wdata_q   <= m_wdata_d;
      m_wstrb_q   <= m_wstrb_d;
    end
  end

  assign rd_grant_o  = rd_grant_q;
  assign m_araddr_o  = m_araddr_q;
  assign m_arprot_o  = m_arprot_q;
  assign m_arcache_o = m_arcache_q;
  assign m_arsize_o  = m_arsize_q;
  assign m_awaddr_o  = m_awaddr_q;
  assign m_awprot_o  = m_awprot_q;
  assign m_wdata_o   = m_wdata_q;
  assign m_wstrb_o   = m_wstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_core_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_axi_core_bus_arbiter : directed tests for axi_core_bus_arbiter        |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_axi_core_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_arvalid, i_rready;
  logic [31:0] i_araddr;
  logic [2:0]  i_arprot;
  logic [3:0]  i_arcache;
  logic [1:0]  i_arsize;
  logic        d_arvalid, d_rready, d_awvalid, d_wvalid, d_bready;
  logic [31:0] d_araddr, d_awaddr, d_wdata;
  logic [2:0]  d_arprot, d_awprot;
  logic [3:0]  d_wstrb;
  logic        m_arready, m_rvalid, m_awready, m_wready, m_bvalid;
  logic [31:0] m_rdata;

  logic        i_arready, i_rvalid, d_arready, d_rvalid, d_awready, d_wready, d_bvalid;
  logic [31:0] i_rdata, d_rdata;
  logic        m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, rd_grant;
  logic [31:0] m_araddr, m_awaddr, m_wdata;
  logic [2:0]  m_arprot, m_arsize, m_awprot;
  logic [3:0]  m_arcache, m_wstrb;

  logic        df_i_arready, df_i_rvalid, df_d_arready, df_d_rvalid, df_d_awready;
  logic        df_d_wready, df_d_bvalid;
  logic [31:0] df_i_rdata, df_d_rdata;
  logic        df_m_arvalid, df_m_rready, df_m_awvalid, df_m_wvalid, df_m_bready, df_rd_grant;
  logic [31:0] df_m_araddr, df_m_awaddr, df_m_wdata;
  logic [2:0]  df_m_arprot, df_m_arsize, df_m_awprot;
  logic [3:0]  df_m_arcache, df_m_wstrb;

  int n_cmp = 0;
  int n_err = 0;

  axi_core_bus_arbiter #(.ARB_MODE("RR"), .ADDR_WIDTH(32), .DATA_WIDTH(32)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .i_arvalid_i(i_arvalid), .i_arready_o(i_arready), .i_araddr_i(i_araddr),
    .i_arprot_i(i_arprot), .i_arcache_i(i_arcache), .i_arsize_i(i_arsize),
    .i_rvalid_o(i_rvalid), .i_rready_i(i_rready), .i_rdata_o(i_rdata),
    .d_arvalid_i(d_arvalid), .d_arready_o(d_arready), .d_araddr_i(d_araddr),
    .d_arprot_i(d_arprot), .d_rvalid_o(d_rvalid), .d_rready_i(d_rready), .d_rdata_o(d_rdata),
    .d_awvalid_i(d_awvalid), .d_awready_o(d_awready), .d_awaddr_i(d_awaddr),
    .d_awprot_i(d_awprot), .d_wvalid_i(d_wvalid), .d_wready_o(d_wready),
    .d_wdata_i(d_wdata), .d_wstrb_i(d_wstrb), .d_bvalid_o(d_bvalid), .d_bready_i(d_bready),
    .m_arvalid_o(m_arvalid), .m_arready_i(m_arready), .m_araddr_o(m_araddr),
    .m_arprot_o(m_arprot), .m_arcache_o(m_arcache), .m_arsize_o(m_arsize),
    .m_rvalid_i(m_rvalid), .m_rready_o(m_rready), .m_rdata_i(m_rdata),
    .m_awvalid_o(m_awvalid), .m_awready_i(m_awready), .m_awaddr_o(m_awaddr),
    .m_awprot_o(m_awprot), .m_wvalid_o(m_wvalid), .m_wready_i(m_wready),
    .m_wdata_o(m_wdata), .m_wstrb_o(m_wstrb), .m_bvalid_i(m_bvalid), .m_bready_o(m_bready),
    .rd_grant_o(rd_grant)
  );

  axi_core_bus_arbiter #(.ARB_MODE("DATA_FIRST"), .ADDR_WIDTH(32), .DATA_WIDTH(32)) u_dut_df (
    .clk_i(clk), .rst_ni(rst_n),
    .i_arvalid_i(i_arvalid), .i_arready_o(df_i_arready), .i_araddr_i(i_araddr),
    .i_arprot_i(i_arprot), .i_arcache_i(i_arcache), .i_arsize_i(i_arsize),
    .i_rvalid_o(df_i_rvalid), .i_rready_i(i_rready), .i_rdata_o(df_i_rdata),
    .d_arvalid_i(d_arvalid), .d_arready_o(df_d_arready), .d_araddr_i(d_araddr),
    .d_arprot_i(d_arprot), .d_rvalid_o(df_d_rvalid), .d_rready_i(d_rready), .d_rdata_o(df_d_rdata),
    .d_awvalid_i(d_awvalid), .d_awready_o(df_d_awready), .d_awaddr_i(d_awaddr),
    .d_awprot_i(d_awprot), .d_wvalid_i(d_wvalid), .d_wready_o(df_d_wready),
    .d_wdata_i(d_wdata), .d_wstrb_i(d_wstrb), .d_bvalid_o(df_d_bvalid), .d_bready_i(d_bready),
    .m_arvalid_o(df_m_arvalid), .m_arready_i(m_arready), .m_araddr_o(df_m_araddr),
    .m_arprot_o(df_m_arprot), .m_arcache_o(df_m_arcache), .m_arsize_o(df_m_arsize),
    .m_rvalid_i(m_rvalid), .m_rready_o(df_m_rready), .m_rdata_i(m_rdata),
    .m_awvalid_o(df_m_awvalid), .m_awready_i(m_awready), .m_awaddr_o(df_m_awaddr),
    .m_awprot_o(df_m_awprot), .m_wvalid_o(df_m_wvalid), .m_wready_i(m_wready),
    .m_wdata_o(df_m_wdata), .m_wstrb_o(df_m_wstrb), .m_bvalid_i(m_bvalid), .m_bready_o(df_m_bready),
    .rd_grant_o(df_rd_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    i_arvalid = 0; i_araddr = '0; i_arprot = '0; i_arcache = '0; i_arsize = '0; i_rready = 1;
    d_arvalid = 0; d_araddr = '0; d_arprot = '0; d_rready = 1;
    d_awvalid = 0; d_awaddr = '0; d_awprot = '0; d_wvalid = 0; d_wdata = '0; d_wstrb = '0;
    d_bready = 1;
    m_arready = 0; m_rvalid = 0; m_rdata = '0; m_awready = 0; m_wready = 0; m_bvalid = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  // Slave side completion of a read that is currently in R_ADDR
  task automatic finish_read(input logic [31:0] data);
    @(negedge clk); m_arready = 1;
    @(negedge clk); m_arready = 0; m_rvalid = 1; m_rdata = data;
    @(negedge clk); m_rvalid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    @(negedge clk); #1;
    n_cmp++; if (m_arvalid !== 1'b0) begin n_err++; $display("FAIL rst_m_arvalid: got %0h want 0", m_arvalid); end
    n_cmp++; if (m_awvalid !== 1'b0 || m_wvalid !== 1'b0) begin n_err++; $display("FAIL rst_m_aw_w_valid: got %0h%0h want 00", m_awvalid, m_wvalid); end
    n_cmp++; if (m_rready !== 1'b0 || m_bready !== 1'b0) begin n_err++; $display("FAIL rst_m_readies: got %0h%0h want 00", m_rready, m_bready); end
    n_cmp++; if (rd_grant !== 1'b0) begin n_err++; $display("FAIL rst_rd_grant: got %0h want 0", rd_grant); end
    n_cmp++; if (m_araddr !== 32'h0 || m_awaddr !== 32'h0 || m_wdata !== 32'h0 || m_wstrb !== 4'h0) begin n_err++; $display("FAIL rst_m_fields: got %h %h %h %h want 0", m_araddr, m_awaddr, m_wdata, m_wstrb); end
    n_cmp++; if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || d_bvalid !== 1'b0) begin n_err++; $display("FAIL rst_core_valids: got %0h%0h%0h want 000", i_rvalid, d_rvalid, d_bvalid); end
    rst_n = 1;
  endtask

  task automatic test_instr_read();
    do_reset();
    @(negedge clk);
    i_arvalid = 1; i_araddr = 32'h100; i_arsize = 2'b10; i_arcache = 4'hF; i_arprot = 3'b100;
    #1;
    n_cmp++; if (i_arready !== 1'b1 || d_arready !== 1'b0) begin n_err++; $display("FAIL ir_arready: got i%0h d%0h want i1 d0", i_arready, d_arready); end
    n_cmp++; if (m_arvalid !== 1'b0) begin n_err++; $display("FAIL ir_arvalid_n: got %0h want 0", m_arvalid); end
    @(negedge clk); i_arvalid = 0; #1;
    n_cmp++; if (m_arvalid !== 1'b1) begin n_err++; $display("FAIL ir_arvalid_n1: got %0h want 1", m_arvalid); end
    n_cmp++; if (m_araddr !== 32'h100) begin n_err++; $display("FAIL ir_araddr: got %h want 00000100", m_araddr); end
    n_cmp++; if (m_arsize !== 3'b010 || m_arcache !== 4'hF || m_arprot !== 3'b100) begin n_err++; $display("FAIL ir_fields: got size %b cache %h prot %b want 010 f 100", m_arsize, m_arcache, m_arprot); end
    n_cmp++; if (rd_grant !== 1'b0) begin n_err++; $display("FAIL ir_grant: got %0h want 0", rd_grant); end
    @(negedge clk); #1;
    n_cmp++; if (m_arvalid !== 1'b1 || i_arready !== 1'b0) begin n_err++; $display("FAIL ir_arvalid_hold: got v%0h r%0h want v1 r0", m_arvalid, i_arready); end
    m_arready = 1;
    @(negedge clk); m_arready = 0; m_rvalid = 1; m_rdata = 32'h00000013; #1;
    n_cmp++; if (m_arvalid !== 1'b0 || m_rready !== 1'b1) begin n_err++; $display("FAIL ir_rdata_phase: got v%0h rr%0h want v0 rr1", m_arvalid, m_rready); end
    n_cmp++; if (i_rvalid !== 1'b1 || i_rdata !== 32'h00000013) begin n_err++; $display("FAIL ir_rdata: got %0h %h want 1 00000013", i_rvalid, i_rdata); end
    n_cmp++; if (d_rvalid !== 1'b0) begin n_err++; $display("FAIL ir_d_rvalid: got %0h want 0", d_rvalid); end
    @(negedge clk); m_rvalid = 0; #1;
    n_cmp++; if (m_rready !== 1'b0 || i_rvalid !== 1'b0) begin n_err++; $display("FAIL ir_done: got rr%0h rv%0h want 0 0", m_rready, i_rvalid); end
  endtask

  task automatic test_rr();
    do_reset();
    @(negedge clk);
    i_arvalid = 1; i_araddr = 32'h200; i_arsize = 2'b10; i_arcache = 4'h3;
    d_arvalid = 1; d_araddr = 32'h8000; d_arprot = 3'b001;
    #1;
    n_cmp++; if (i_arready !== 1'b1 || d_arready !== 1'b0) begin n_err++; $display("FAIL rr_first: got i%0h d%0h want i1 d0", i_arready, d_arready); end
    @(negedge clk); #1;
    n_cmp++; if (rd_grant !== 1'b0 || m_araddr !== 32'h200) begin n_err++; $display("FAIL rr_first_ar: got g%0h %h want g0 00000200", rd_grant, m_araddr); end
    n_cmp++; if (i_arready !== 1'b0 || d_arready !== 1'b0) begin n_err++; $display("FAIL rr_busy_ready: got i%0h d%0h want 0 0", i_arready, d_arready); end
    m_arready = 1;
    @(negedge clk); m_arready = 0; m_rvalid = 1; m_rdata = 32'h11; #1;
    n_cmp++; if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0) begin n_err++; $display("FAIL rr_r_route: got i%0h d%0h want 1 0", i_rvalid, d_rvalid); end
    @(negedge clk); m_rvalid = 0; #1;
    n_cmp++; if (d_arready !== 1'b1 || i_arready !== 1'b0) begin n_err++; $display("FAIL rr_second: got i%0h d%0h want i0 d1", i_arready, d_arready); end
    @(negedge clk); i_arvalid = 0; d_arvalid = 0; #1;
    n_cmp++; if (rd_grant !== 1'b1 || m_araddr !== 32'h8000) begin n_err++; $display("FAIL rr_second_ar: got g%0h %h want g1 00008000", rd_grant, m_araddr); end
    n_cmp++; if (m_arsize !== 3'b010 || m_arcache !== 4'h0 || m_arprot !== 3'b001) begin n_err++; $display("FAIL rr_d_fields: got %b %h %b want 010 0 001", m_arsize, m_arcache, m_arprot); end
    m_arready = 1;
    @(negedge clk); m_arready = 0; m_rvalid = 1; m_rdata = 32'hCAFE0001; #1;
    n_cmp++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hCAFE0001 || i_rvalid !== 1'b0) begin n_err++; $display("FAIL rr_d_rdata: got d%0h %h i%0h want 1 cafe0001 0", d_rvalid, d_rdata, i_rvalid); end
    @(negedge clk); m_rvalid = 0;
  endtask

  task automatic test_data_first();
    do_reset();
    @(negedge clk);
    i_arvalid = 1; i_araddr = 32'h200; i_arsize = 2'b10;
    d_arvalid = 1; d_araddr = 32'h8000;
    #1;
    n_cmp++; if (df_d_arready !== 1'b1 || df_i_arready !== 1'b0) begin n_err++; $display("FAIL df_first: got i%0h d%0h want i0 d1", df_i_arready, df_d_arready); end
    @(negedge clk); i_arvalid = 0; d_arvalid = 0; #1;
    n_cmp++; if (df_rd_grant !== 1'b1 || df_m_araddr !== 32'h8000 || df_m_arvalid !== 1'b1) begin n_err++; $display("FAIL df_ar: got g%0h %h v%0h want g1 00008000 v1", df_rd_grant, df_m_araddr, df_m_arvalid); end
  endtask

  task automatic test_store_load();
    do_reset();
    @(negedge clk);
    d_awvalid = 1; d_awaddr = 32'h8000; d_awprot = 3'b000;
    d_wvalid = 1; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
    #1;
    n_cmp++; if (d_awready !== 1'b1 || d_wready !== 1'b1) begin n_err++; $display("FAIL sl_aw_w_ready: got %0h%0h want 11", d_awready, d_wready); end
    @(negedge clk);
    d_awvalid = 0; d_wvalid = 0; d_arvalid = 1; d_araddr = 32'h8000;
    #1;
    n_cmp++; if (m_awvalid !== 1'b1 || m_wvalid !== 1'b1) begin n_err++; $display("FAIL sl_m_valids: got %0h%0h want 11", m_awvalid, m_wvalid); end
    n_cmp++; if (m_awaddr !== 32'h8000 || m_wdata !== 32'hDEADBEEF || m_wstrb !== 4'hF) begin n_err++; $display("FAIL sl_m_fields: got %h %h %h want 00008000 deadbeef f", m_awaddr, m_wdata, m_wstrb); end
    n_cmp++; if (d_arready !== 1'b0) begin n_err++; $display("FAIL sl_ar_blocked_addr: got %0h want 0", d_arready); end
    m_awready = 1; m_wready = 1;
    @(negedge clk); m_awready = 0; m_wready = 0; #1;
    n_cmp++; if (m_awvalid !== 1'b0 || m_wvalid !== 1'b0) begin n_err++; $display("FAIL sl_resp_valids: got %0h%0h want 00", m_awvalid, m_wvalid); end
    n_cmp++; if (m_arvalid !== 1'b0 || d_arready !== 1'b0) begin n_err++; $display("FAIL sl_ar_blocked_resp: got v%0h r%0h want 0 0", m_arvalid, d_arready); end
    @(negedge clk); m_bvalid = 1; #1;
    n_cmp++; if (d_bvalid !== 1'b1 || m_bready !== 1'b1 || m_arvalid !== 1'b0) begin n_err++; $display("FAIL sl_b: got bv%0h br%0h arv%0h want 1 1 0", d_bvalid, m_bready, m_arvalid); end
    @(negedge clk); m_bvalid = 0; #1;
    n_cmp++; if (d_arready !== 1'b1 || d_bvalid !== 1'b0) begin n_err++; $display("FAIL sl_ar_after_b: got r%0h bv%0h want 1 0", d_arready, d_bvalid); end
    @(negedge clk); d_arvalid = 0; #1;
    n_cmp++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h8000 || rd_grant !== 1'b1) begin n_err++; $display("FAIL sl_read_issue: got v%0h %h g%0h want 1 00008000 1", m_arvalid, m_araddr, rd_grant); end
    finish_read(32'hDEADBEEF);
  endtask

  task automatic test_w_before_aw();
    do_reset();
    @(negedge clk);
    d_wvalid = 1; d_wdata = 32'h12345678; d_wstrb = 4'h3;
    #1;
    n_cmp++; if (d_wready !== 1'b0 || d_awready !== 1'b0) begin n_err++; $display("FAIL wa_early_w: got w%0h aw%0h want 0 0", d_wready, d_awready); end
    @(negedge clk); d_awvalid = 1; d_awaddr = 32'h40; d_awprot = 3'b010; #1;
    n_cmp++; if (d_awready !== 1'b1 || d_wready !== 1'b1) begin n_err++; $display("FAIL wa_accept: got aw%0h w%0h want 1 1", d_awready, d_wready); end
    @(negedge clk); d_awvalid = 0; d_wvalid = 0; m_wready = 1; #1;
    n_cmp++; if (m_awvalid !== 1'b1 || m_wvalid !== 1'b1 || d_wready !== 1'b0) begin n_err++; $display("FAIL wa_both_valid: got aw%0h w%0h dw%0h want 1 1 0", m_awvalid, m_wvalid, d_wready); end
    n_cmp++; if (m_wdata !== 32'h12345678 || m_wstrb !== 4'h3 || m_awaddr !== 32'h40 || m_awprot !== 3'b010) begin n_err++; $display("FAIL wa_fields: got %h %h %h %b want 12345678 3 00000040 010", m_wdata, m_wstrb, m_awaddr, m_awprot); end
    @(negedge clk); m_wready = 0; #1;
    n_cmp++; if (m_wvalid !== 1'b0 || m_awvalid !== 1'b1) begin n_err++; $display("FAIL wa_w_done: got w%0h aw%0h want 0 1", m_wvalid, m_awvalid); end
    @(negedge clk); #1;
    n_cmp++; if (m_awvalid !== 1'b1 || d_bvalid !== 1'b0) begin n_err++; $display("FAIL wa_aw_wait: got aw%0h bv%0h want 1 0", m_awvalid, d_bvalid); end
    @(negedge clk); m_awready = 1; m_bvalid = 1; #1;
    n_cmp++; if (m_awvalid !== 1'b1 || d_bvalid !== 1'b0) begin n_err++; $display("FAIL wa_aw_fire: got aw%0h bv%0h want 1 0", m_awvalid, d_bvalid); end
    @(negedge clk); m_awready = 0; #1;
    n_cmp++; if (m_awvalid !== 1'b0 || d_bvalid !== 1'b1 || m_bready !== 1'b1) begin n_err++; $display("FAIL wa_b: got aw%0h bv%0h br%0h want 0 1 1", m_awvalid, d_bvalid, m_bready); end
    @(negedge clk); #1;
    n_cmp++; if (d_bvalid !== 1'b0 || m_bready !== 1'b0) begin n_err++; $display("FAIL wa_single_b: got bv%0h br%0h want 0 0", d_bvalid, m_bready); end
    m_bvalid = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk); i_arvalid = 1; i_araddr = 32'h300; i_arsize = 2'b10;
    @(negedge clk); i_arvalid = 0; m_arready = 1;
    @(negedge clk); m_arready = 0; m_rvalid = 1; m_rdata = 32'h55; #1;
    n_cmp++; if (i_rvalid !== 1'b1 || m_rready !== 1'b1) begin n_err++; $display("FAIL rm_pre: got rv%0h rr%0h want 1 1", i_rvalid, m_rready); end
    #1 rst_n = 0;
    #1;
    n_cmp++; if (i_rvalid !== 1'b0 || m_rready !== 1'b0 || m_arvalid !== 1'b0) begin n_err++; $display("FAIL rm_async: got rv%0h rr%0h arv%0h want 0 0 0", i_rvalid, m_rready, m_arvalid); end
    n_cmp++; if (m_araddr !== 32'h0 || rd_grant !== 1'b0) begin n_err++; $display("FAIL rm_regs: got %h g%0h want 0 0", m_araddr, rd_grant); end
    @(negedge clk); rst_n = 1; m_rvalid = 0;
    @(negedge clk); i_arvalid = 1; i_araddr = 32'h400; #1;
    n_cmp++; if (i_arready !== 1'b1) begin n_err++; $display("FAIL rm_regrant: got %0h want 1", i_arready); end
    @(negedge clk); i_arvalid = 0; #1;
    n_cmp++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h400) begin n_err++; $display("FAIL rm_new_ar: got v%0h %h want 1 00000400", m_arvalid, m_araddr); end
    finish_read(32'h66);
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    test_reset();
    test_instr_read();
    test_rr();
    test_data_first();
    test_store_load();
    test_w_before_aw();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
